// File: rtl/round_robin_requester_2ch.sv
// Two-channel FIFO front-end for a 2-request round-robin arbiter: each channel
// requests while non-empty and pops its head onto a shared registered output bus when granted.
module round_robin_requester_2ch #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_data,
  output logic [1:0]       requests,
  input  logic [1:0]       grants,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_id,
  output logic             grant_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [1:0]       w_in_valid;
  logic [1:0]       w_ready;
  logic [1:0]       w_push;
  logic [1:0]       w_pop;
  logic [WIDTH-1:0] w_in_data [2];
  logic [WIDTH-1:0] w_head    [2];
  logic             w_grant_ok;
  logic             w_grant_bad;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_id;
  logic             r_grant_err;

  assign w_in_valid   = {in1_valid, in0_valid};
  assign w_in_data[0] = in0_data;
  assign w_in_data[1] = in1_data;
  assign in0_ready    = w_ready[0];
  assign in1_ready    = w_ready[1];

  // A grant pops only if it is one-hot and aimed at a channel that is actually requesting.
  always_comb begin
    w_grant_ok  = ((grants == 2'b01) && requests[0]) || ((grants == 2'b10) && requests[1]);
    w_grant_bad = (grants == 2'b11) || ((grants & ~requests) != 2'b00);
    w_pop       = w_grant_ok ? grants : 2'b00;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic [WIDTH-1:0] r_mem [DEPTH];
      logic [AW-1:0]    r_wptr;
      logic [AW-1:0]    r_rptr;
      logic [CW-1:0]    r_count;

      assign w_ready[gi]  = (r_count != CNT_FULL);
      assign requests[gi] = (r_count != '0);
      assign w_push[gi]   = w_in_valid[gi] & w_ready[gi];
      assign w_head[gi]   = r_mem[r_rptr];

      always_ff @(posedge clk) begin
        if (w_push[gi]) r_mem[r_wptr] <= w_in_data[gi];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_wptr  <= '0;
          r_rptr  <= '0;
          r_count <= '0;
        end else begin
          if (w_push[gi]) r_wptr <= r_wptr + PTR_ONE;
          if (w_pop[gi])  r_rptr <= r_rptr + PTR_ONE;
          case ({w_push[gi], w_pop[gi]})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
          endcase
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= 1'b0;
      r_grant_err <= 1'b0;
    end else begin
      r_out_valid <= |w_pop;
      if (|w_pop) begin
        r_out_data <= w_pop[1] ? w_head[1] : w_head[0];
        r_out_id   <= w_pop[1];
      end
      if (w_grant_bad) r_grant_err <= 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign grant_err = r_grant_err;

endmodule

// File: tb/tb_round_robin_requester_2ch.sv
// Directed bench for round_robin_requester_2ch: hand-computed expectations
// checked with immediate assertions, one line per comparison.
module tb_round_robin_requester_2ch;

  logic       clk = 1'b0;
  logic       rst;
  logic       in0_valid, in1_valid;
  logic       in0_ready, in1_ready;
  logic [7:0] in0_data, in1_data;
  logic [1:0] requests, grants;
  logic       out_valid, out_id, grant_err;
  logic [7:0] out_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_rr [8] = '{8'd1, 8'd5, 8'd2, 8'd6, 8'd3, 8'd7, 8'd4, 8'd8};

  round_robin_requester_2ch #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
    .requests(requests), .grants(grants),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .grant_err(grant_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    if (obs === exp) $display("ok   %s = 0x%0h", tag, obs);
  endtask

  initial begin
    rst = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0;
    in0_data = '0; in1_data = '0; grants = 2'b00;
    #12;
    check("rst_requests",  32'(requests),  0);
    check("rst_in0_ready", 32'(in0_ready), 1);
    check("rst_in1_ready", 32'(in1_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data",  32'(out_data),  0);
    check("rst_out_id",    32'(out_id),    0);
    check("rst_grant_err", 32'(grant_err), 0);
    step(); rst = 1'b0;
    step(); step();
    check("idle_requests",  32'(requests),  0);
    check("idle_out_valid", 32'(out_valid), 0);
    check("idle_grant_err", 32'(grant_err), 0);

    // Single word on channel 0
    in0_valid = 1'b1; in0_data = 8'hA5;
    step();
    in0_valid = 1'b0;
    check("single_requests", 32'(requests), 1);
    grants = 2'b01;
    step();
    grants = 2'b00;
    check("single_out_valid", 32'(out_valid), 1);
    check("single_out_data",  32'(out_data),  'hA5);
    check("single_out_id",    32'(out_id),    0);
    check("single_requests0", 32'(requests),  0);
    step();
    check("single_beat_ends", 32'(out_valid), 0);
    check("single_data_hold", 32'(out_data),  'hA5);

    // Fill both channels, then alternate grants
    for (int k = 0; k < 4; k++) begin
      in0_valid = 1'b1; in0_data = 8'(k + 1);
      in1_valid = 1'b1; in1_data = 8'(k + 5);
      step();
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
    check("fill_in0_ready", 32'(in0_ready), 0);
    check("fill_in1_ready", 32'(in1_ready), 0);
    check("fill_requests",  32'(requests),  3);
    for (int k = 0; k < 8; k++) begin
      grants = (k % 2 == 0) ? 2'b01 : 2'b10;
      step();
      check($sformatf("rr%0d_valid", k), 32'(out_valid), 1);
      check($sformatf("rr%0d_data", k),  32'(out_data),  32'(exp_rr[k]));
      check($sformatf("rr%0d_id", k),    32'(out_id),    32'(k % 2));
    end
    grants = 2'b00;
    check("rr_requests_empty", 32'(requests), 0);
    step();
    check("rr_drained_valid", 32'(out_valid), 0);

    // Full channel 1 with valid held while popping
    for (int k = 0; k < 4; k++) begin
      in1_valid = 1'b1; in1_data = 8'(8'h10 + k);
      step();
    end
    check("full_in1_ready", 32'(in1_ready), 0);
    in1_data = 8'h14;
    grants = 2'b10;
    step();
    grants = 2'b00;
    check("full_pop_valid", 32'(out_valid), 1);
    check("full_pop_data",  32'(out_data),  'h10);
    check("full_pop_id",    32'(out_id),    1);
    check("full_ready_up",  32'(in1_ready), 1);
    step();
    in1_valid = 1'b0;
    check("full_one_beat",  32'(out_valid), 0);
    check("full_refilled",  32'(in1_ready), 0);
    for (int k = 0; k < 4; k++) begin
      grants = 2'b10;
      step();
      check($sformatf("full_drain%0d_data", k), 32'(out_data), 32'('h11 + k));
      check($sformatf("full_drain%0d_valid", k), 32'(out_valid), 1);
    end
    grants = 2'b00;
    check("full_drain_requests", 32'(requests), 0);

    // Illegal: both grants at once
    in0_valid = 1'b1; in0_data = 8'h21;
    in1_valid = 1'b1; in1_data = 8'h31;
    step();
    in0_valid = 1'b0; in1_valid = 1'b0;
    grants = 2'b11;
    step();
    grants = 2'b00;
    check("g11_out_valid", 32'(out_valid), 0);
    check("g11_grant_err", 32'(grant_err), 1);
    check("g11_requests",  32'(requests),  3);
    check("g11_data_hold", 32'(out_data),  'h14);
    grants = 2'b01;
    step();
    check("g11_ch0_intact", 32'(out_data), 'h21);
    grants = 2'b10;
    step();
    grants = 2'b00;
    check("g11_ch1_intact", 32'(out_data), 'h31);
    check("g11_err_sticky", 32'(grant_err), 1);
    check("g11_requests0",  32'(requests),  0);

    // Illegal: grant to an empty channel (reset first to clear the sticky flag)
    rst = 1'b1; step(); rst = 1'b0;
    check("g10_err_cleared", 32'(grant_err), 0);
    in0_valid = 1'b1; in0_data = 8'h41;
    step();
    in0_valid = 1'b0;
    grants = 2'b10;
    step();
    grants = 2'b00;
    check("g10_out_valid", 32'(out_valid), 0);
    check("g10_grant_err", 32'(grant_err), 1);
    check("g10_requests",  32'(requests),  1);
    grants = 2'b01;
    step();
    grants = 2'b00;
    check("g10_ch0_intact", 32'(out_data), 'h41);
    check("g10_ch0_valid",  32'(out_valid), 1);

    // Reset mid-stream with an output beat in flight
    for (int k = 0; k < 3; k++) begin
      in0_valid = 1'b1; in0_data = 8'(8'h51 + k);
      step();
    end
    in0_valid = 1'b0;
    grants = 2'b01;
    step();
    check("mid_beat_valid", 32'(out_valid), 1);
    check("mid_beat_data",  32'(out_data),  'h51);
    #2 rst = 1'b1;
    #1;
    grants = 2'b00;
    check("mid_rst_valid",    32'(out_valid), 0);
    check("mid_rst_requests", 32'(requests),  0);
    check("mid_rst_in0_rdy",  32'(in0_ready), 1);
    check("mid_rst_err",      32'(grant_err), 0);
    step(); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("mid_post%0d_valid", k), 32'(out_valid), 0);
      check($sformatf("mid_post%0d_req", k),   32'(requests),  0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
